// File: rtl/rtc_tick_timer.sv
// rtc_tick_timer
//   Consumer side of the divided RTC clock. Synchronises rtc_clk_i into the
//   core clock domain and detects its rising edges. Each edge produces a
//   one-cycle tick and drives a prescaled, free-running time counter that has
//   a level-sensitive compare interrupt. The rtc period is also measured in
//   core cycles, as a health/frequency check on the divider.
//
// Ports
//   clk, rst       core clock, asynchronous active-high reset
//   rtc_clk_i      divided rtc clock (asynchronous to clk)
//   en             counter/prescaler enable
//   cnt_wr_en/data load time counter (wins over a coincident rtc edge)
//   cmp_wr_en/data load compare register
//   tick_o         one-cycle pulse per detected rtc rising edge
//   cnt_o, cmp_o   time counter and compare register
//   irq_o          level interrupt, cnt_o >= cmp_o (unsigned)
//   period_o       last measured rtc period in clk cycles (saturating)
//   period_vld_o   period_o holds a valid measurement
module rtc_tick_timer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRESC = 1,
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rtc_clk_i,
  input  logic             en,
  input  logic             cnt_wr_en,
  input  logic [CNT_W-1:0] cnt_wr_data,
  input  logic             cmp_wr_en,
  input  logic [CNT_W-1:0] cmp_wr_data,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic             irq_o,
  output logic [PER_W-1:0] period_o,
  output logic             period_vld_o
);

  localparam int unsigned PSC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESC - 1);

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             irq_q, irq_d;
  logic [PSC_W-1:0] presc_q, presc_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] per_inc;
  logic [PER_W-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic [1:0]       edge_cnt_q, edge_cnt_d;

  always_comb begin
    rise = s2_q & ~s3_q;
    tick_d = rise;

    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (cnt_wr_en) begin
      cnt_d   = cnt_wr_data;
      presc_d = '0;
    end else if (rise && en) begin
      if (presc_q == PSC_LAST) begin
        presc_d = '0;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        presc_d = presc_q + PSC_W'(1);
      end
    end

    cmp_d = cmp_wr_en ? cmp_wr_data : cmp_q;
    // Compare the values being registered so irq_o lines up with cnt_o/cmp_o.
    irq_d = (cnt_d >= cmp_d);

    // per_inc is both the next free-running count and the period captured on
    // a rise, since the rise cycle itself belongs to the elapsed period.
    per_inc      = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
    per_cnt_d    = per_inc;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    edge_cnt_d   = edge_cnt_q;
    if (rise) begin
      per_cnt_d = '0;
      if (edge_cnt_q != 2'd2) begin
        edge_cnt_d = edge_cnt_q + 2'd1;
      end
      if (edge_cnt_q != 2'd0) begin
        period_d     = per_inc;
        period_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      tick_q       <= 1'b0;
      cnt_q        <= '0;
      cmp_q        <= '1;
      irq_q        <= 1'b0;
      presc_q      <= '0;
      per_cnt_q    <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      edge_cnt_q   <= 2'd0;
    end else begin
      s1_q         <= rtc_clk_i;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      tick_q       <= tick_d;
      cnt_q        <= cnt_d;
      cmp_q        <= cmp_d;
      irq_q        <= irq_d;
      presc_q      <= presc_d;
      per_cnt_q    <= per_cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign tick_o       = tick_q;
  assign cnt_o        = cnt_q;
  assign cmp_o        = cmp_q;
  assign irq_o        = irq_q;
  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;

endmodule

// File: tb/tb_rtc_tick_timer.sv
// Testbench for rtc_tick_timer: two instances (PRESC=1 and PRESC=4) share
// stimulus. Expected values are queued when an rtc rising edge is driven and
// compared when the DUT emits tick_o.
module tb_rtc_tick_timer;

  localparam int unsigned P4 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtc_clk_i;
  logic        en;
  logic        cnt_wr_en;
  logic [31:0] cnt_wr_data;
  logic        cmp_wr_en;
  logic [31:0] cmp_wr_data;

  logic        tick1, irq1, vld1;
  logic [31:0] cnt1, cmp1;
  logic [15:0] per1;
  logic        tick4, irq4, vld4;
  logic [31:0] cnt4, cmp4;
  logic [15:0] per4;

  always #5 clk = ~clk;

  rtc_tick_timer u_dut1 (
    .clk(clk), .rst(rst), .rtc_clk_i(rtc_clk_i), .en(en),
    .cnt_wr_en(cnt_wr_en), .cnt_wr_data(cnt_wr_data),
    .cmp_wr_en(cmp_wr_en), .cmp_wr_data(cmp_wr_data),
    .tick_o(tick1), .cnt_o(cnt1), .cmp_o(cmp1), .irq_o(irq1),
    .period_o(per1), .period_vld_o(vld1)
  );

  rtc_tick_timer #(.PRESC(P4)) u_dut4 (
    .clk(clk), .rst(rst), .rtc_clk_i(rtc_clk_i), .en(en),
    .cnt_wr_en(cnt_wr_en), .cnt_wr_data(cnt_wr_data),
    .cmp_wr_en(cmp_wr_en), .cmp_wr_data(cmp_wr_data),
    .tick_o(tick4), .cnt_o(cnt4), .cmp_o(cmp4), .irq_o(irq4),
    .period_o(per4), .period_vld_o(vld4)
  );

  typedef struct {
    logic [31:0] cnt1;
    logic [31:0] cnt4;
    logic [15:0] per;
    logic        vld;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int unsigned step_cnt = 0;
  int unsigned last_high_step = 0;
  int unsigned m_rises = 0;
  int unsigned m_p4 = 0;
  logic [31:0] m_cnt1 = '0;
  logic [31:0] m_cnt4 = '0;
  logic [31:0] m_cmp  = '1;
  logic [15:0] m_last_per = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_cnt++;
  endtask

  task automatic model_reset();
    m_rises = 0; m_p4 = 0; m_cnt1 = '0; m_cnt4 = '0; m_cmp = '1; m_last_per = '0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_cnt1"}, cnt1, 32'h0);
    check({pfx, "_cnt4"}, cnt4, 32'h0);
    check({pfx, "_cmp"},  cmp1, 32'hFFFF_FFFF);
    check({pfx, "_irq"},  {31'b0, irq1}, 32'h0);
    check({pfx, "_tick"}, {31'b0, tick1}, 32'h0);
    check({pfx, "_vld"},  {31'b0, vld1}, 32'h0);
    check({pfx, "_per"},  {16'b0, per1}, 32'h0);
  endtask

  // Called when rtc_clk_i is driven high; predicts the state at the tick.
  task automatic push_exp(input bit wr_on_rise);
    exp_t e;
    int unsigned diff;
    diff = step_cnt - last_high_step;
    last_high_step = step_cnt;
    m_rises++;
    if (wr_on_rise) begin
      m_cnt1 = 32'h10; m_cnt4 = 32'h10; m_p4 = 0;
    end else if (en) begin
      m_cnt1 = m_cnt1 + 32'd1;
      m_p4++;
      if (m_p4 == P4) begin
        m_p4 = 0;
        m_cnt4 = m_cnt4 + 32'd1;
      end
    end
    if (m_rises >= 2) begin
      m_last_per = (diff > 32'hFFFF) ? 16'hFFFF : diff[15:0];
    end
    e.cnt1 = m_cnt1;
    e.cnt4 = m_cnt4;
    e.per  = m_last_per;
    e.vld  = (m_rises >= 2);
    e.irq  = (m_cnt1 >= m_cmp);
    sb_q.push_back(e);
  endtask

  // 3 cycles low, 3 cycles high; optional counter write during the rise cycle.
  task automatic rtc_pulse(input bit wr_on_rise);
    rtc_clk_i = 1'b0;
    repeat (3) begin
      step();
      check("tick_lo", {31'b0, tick1}, 32'h0);
    end
    rtc_clk_i = 1'b1;
    push_exp(wr_on_rise);
    step();
    check("tick_e0", {31'b0, tick1}, 32'h0);
    step();
    check("tick_e1", {31'b0, tick1}, 32'h0);
    if (wr_on_rise) begin
      cnt_wr_en = 1'b1;
      cnt_wr_data = 32'h10;
    end
    step();
    check("tick_e2", {31'b0, tick1}, 32'h1);
    check("tick4_e2", {31'b0, tick4}, 32'h1);
    cnt_wr_en = 1'b0;
  endtask

  task automatic reg_write(input bit ce, input logic [31:0] cd, input bit me, input logic [31:0] md);
    cnt_wr_en = ce; cnt_wr_data = cd;
    cmp_wr_en = me; cmp_wr_data = md;
    if (ce) begin
      m_cnt1 = cd; m_cnt4 = cd; m_p4 = 0;
    end
    if (me) m_cmp = md;
    step();
    cnt_wr_en = 1'b0;
    cmp_wr_en = 1'b0;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #2;
    if (tick1 === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_tick", 32'h1, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_cnt1", cnt1, mon_e.cnt1);
        check("sb_cnt4", cnt4, mon_e.cnt4);
        check("sb_per",  {16'b0, per1}, {16'b0, mon_e.per});
        check("sb_vld",  {31'b0, vld1}, {31'b0, mon_e.vld});
        check("sb_irq",  {31'b0, irq1}, {31'b0, mon_e.irq});
      end
    end
  end

  initial begin
    rst = 1'b1; rtc_clk_i = 1'b0; en = 1'b1;
    cnt_wr_en = 1'b0; cnt_wr_data = '0; cmp_wr_en = 1'b0; cmp_wr_data = '0;
    repeat (3) step();
    check_reset("rst");
    rst = 1'b0;
    step();

    // free running, both prescalers
    repeat (20) rtc_pulse(1'b0);
    check("cnt1_20", cnt1, 32'd20);
    check("cnt4_20", cnt4, 32'd5);
    check("per_6", {16'b0, per1}, 32'd6);
    check("vld_1", {31'b0, vld1}, 32'h1);

    // disabled: counter holds, ticks continue
    en = 1'b0;
    repeat (8) rtc_pulse(1'b0);
    check("cnt4_hold", cnt4, 32'd5);
    check("cnt1_hold", cnt1, 32'd20);
    en = 1'b1;

    // compare interrupt
    reg_write(1'b1, 32'h0, 1'b1, 32'd3);
    check("irq_cmp3_lo", {31'b0, irq1}, 32'h0);
    repeat (4) rtc_pulse(1'b0);
    check("irq_cmp3_hi", {31'b0, irq1}, 32'h1);
    reg_write(1'b0, 32'h0, 1'b1, 32'd100);
    check("irq_cmp100", {31'b0, irq1}, 32'h0);
    reg_write(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    check("irq_max", {31'b0, irq1}, 32'h1);
    check("cnt_max", cnt1, 32'hFFFF_FFFF);
    rtc_pulse(1'b0);
    check("cnt_wrap", cnt1, 32'h0);
    check("irq_wrap", {31'b0, irq1}, 32'h0);

    // load coincident with rise: load wins, prescaler cleared
    rtc_pulse(1'b1);
    check("wr_rise_cnt1", cnt1, 32'h10);
    check("wr_rise_cnt4", cnt4, 32'h10);
    repeat (4) rtc_pulse(1'b0);
    check("wr_rise_cnt4_p", cnt4, 32'h11);
    check("wr_rise_cnt1_p", cnt1, 32'h14);

    // stopped rtc: period holds, then saturates
    rtc_clk_i = 1'b0;
    repeat (65536 + 50) step();
    check("per_hold_stop", {16'b0, per1}, {16'b0, m_last_per});
    rtc_pulse(1'b0);
    check("per_sat", {16'b0, per1}, 32'hFFFF);
    rtc_pulse(1'b0);
    check("per_after_sat", {16'b0, per1}, 32'd6);

    // asynchronous reset mid-run
    rtc_pulse(1'b0);
    #3;
    rtc_clk_i = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("arst");
    model_reset();
    step();
    step();
    rst = 1'b0;
    rtc_pulse(1'b0);
    check("arst_vld_first", {31'b0, vld1}, 32'h0);
    rtc_pulse(1'b0);
    check("arst_vld_second", {31'b0, vld1}, 32'h1);
    check("arst_per_second", {16'b0, per1}, 32'd6);
    rtc_pulse(1'b0);

    repeat (4) step();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
